// File: rtl/decode_regfile.sv
// Operand-fetch / writeback stage of the 8-bit CPU: decodes the instruction, reads the
// 8x8 register file with result bypass, drives the execute register and commits ALU results.
module decode_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  input  logic             stall,
  input  logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_op_a,
  output logic [WIDTH-1:0] alu_op_b,
  output logic             ex_valid,
  output logic             illegal,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_SUBI = 4'h5;
  localparam logic [3:0] OP_BC   = 4'h6;
  localparam logic [3:0] OP_BS   = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_MVI  = 4'hA;

  logic [WIDTH-1:0] regs_r [NREGS];
  logic [3:0]       ex_opcode_r;
  logic [WIDTH-1:0] ex_a_r;
  logic [WIDTH-1:0] ex_b_r;
  logic [2:0]       ex_rd_r;
  logic             ex_valid_r;
  logic             illegal_r;

  logic [3:0]       opc_s;
  logic [2:0]       rd_s;
  logic [2:0]       rs_s;
  logic [7:0]       imm_s;
  logic [WIDTH-1:0] rd_val_s;
  logic [WIDTH-1:0] rs_val_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic             legal_s;
  logic             accept_s;
  logic             load_s;

  assign opc_s    = instr[15:12];
  assign rd_s     = instr[11:9];
  assign rs_s     = instr[8:6];
  assign imm_s    = instr[7:0];
  assign accept_s = instr_valid & ~stall;
  assign load_s   = accept_s & legal_s;

  // Source reads: the in-flight result wins over the not-yet-written register file entry.
  always_comb begin
    if (ex_valid_r && (ex_rd_r == rd_s)) begin
      rd_val_s = alu_result;
    end else begin
      rd_val_s = regs_r[rd_s];
    end
    if (ex_valid_r && (ex_rd_r == rs_s)) begin
      rs_val_s = alu_result;
    end else begin
      rs_val_s = regs_r[rs_s];
    end
  end

  // Operand selection per opcode class; anything unlisted is undefined.
  always_comb begin
    op_a_s  = {WIDTH{1'b0}};
    op_b_s  = {WIDTH{1'b0}};
    legal_s = 1'b1;
    case (opc_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        op_a_s = rd_val_s;
        op_b_s = rs_val_s;
      end
      OP_ADDI, OP_SUBI, OP_BC, OP_BS: begin
        op_a_s = rd_val_s;
        op_b_s = imm_s;
      end
      OP_MOV, OP_NOT: begin
        op_a_s = rs_val_s;
      end
      OP_MVI: begin
        op_a_s = imm_s;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Execute pipeline register; bubbles keep the previous operands so the ALU inputs stay quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_opcode_r <= 4'h0;
      ex_a_r      <= {WIDTH{1'b0}};
      ex_b_r      <= {WIDTH{1'b0}};
      ex_rd_r     <= 3'd0;
      ex_valid_r  <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      ex_valid_r <= load_s;
      illegal_r  <= accept_s & ~legal_s;
      if (load_s) begin
        ex_opcode_r <= opc_s;
        ex_a_r      <= op_a_s;
        ex_b_r      <= op_b_s;
        ex_rd_r     <= rd_s;
      end else begin
        ex_opcode_r <= ex_opcode_r;
        ex_a_r      <= ex_a_r;
        ex_b_r      <= ex_b_r;
        ex_rd_r     <= ex_rd_r;
      end
    end
  end

  // Register file writeback at the end of each valid execute cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (ex_valid_r) begin
      regs_r[ex_rd_r] <= alu_result;
    end
  end

  assign alu_opcode = ex_opcode_r;
  assign alu_op_a   = ex_a_r;
  assign alu_op_b   = ex_b_r;
  assign ex_valid   = ex_valid_r;
  assign illegal    = illegal_r;
  assign dbg_data   = regs_r[dbg_addr];

endmodule

// File: tb/tb_decode_regfile.sv
// Scoreboard bench for decode_regfile: a program-order architectural model predicts each
// execute-stage output and committed register values; a monitor checks the DUT against them.
module tb_decode_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  alu_result;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_op_a;
  logic [7:0]  alu_op_b;
  logic        ex_valid;
  logic        illegal;
  logic [2:0]  dbg_addr = 3'd0;
  logic [7:0]  dbg_data;

  decode_regfile #(.WIDTH(8), .NREGS(8)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .alu_result(alu_result), .alu_opcode(alu_opcode), .alu_op_a(alu_op_a),
    .alu_op_b(alu_op_b), .ex_valid(ex_valid), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Behavioural ALU for the opcode set
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0, 4'h4: return a + b;
      4'h1, 4'h5: return a - b;
      4'h2:       return a & b;
      4'h3:       return a | b;
      4'h6:       return a & ~b;
      4'h7:       return a | b;
      4'h9:       return ~a;
      default:    return a;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_op_a, alu_op_b);

  typedef struct {
    bit         ill;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         tag;
  } ev_t;

  ev_t        q[$];
  logic [7:0] m[8];
  int         cyc = 0;
  int         total = 0;
  int         passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [15:0] mk_r(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
    return {op, rd, rs, 6'b000000};
  endfunction

  function automatic logic [15:0] mk_i(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
    return {op, rd, 1'b0, imm};
  endfunction

  // Architectural model: instructions take effect in program order, so reading m is the bypassed value
  task automatic model(input logic [15:0] w, input int tag);
    ev_t e;
    logic [3:0] op = w[15:12];
    logic [2:0] rd = w[11:9];
    logic [2:0] rs = w[8:6];
    logic [7:0] imm = w[7:0];
    e.ill = 1'b0; e.op = op; e.a = 8'h00; e.b = 8'h00; e.tag = tag;
    if (op <= 4'h3) begin e.a = m[rd]; e.b = m[rs]; end
    else if (op <= 4'h7) begin e.a = m[rd]; e.b = imm; end
    else if (op <= 4'h9) begin e.a = m[rs]; end
    else if (op == 4'hA) begin e.a = imm; end
    else e.ill = 1'b1;
    if (!e.ill) m[rd] = alu_f(op, e.a, e.b);
    q.push_back(e);
  endtask

  task automatic issue(input logic v, input logic s, input logic [15:0] w);
    @(negedge clk);
    instr = w; instr_valid = v; stall = s;
    if (v && !s) model(w, cyc + 1);
  endtask

  task automatic drain();
    issue(1'b0, 1'b0, 16'h0000);
    issue(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic dbg_check();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), 32'(dbg_data), 32'(m[i]));
    end
  endtask

  task automatic outputs_zero(input string tagname);
    chk({tagname, "_opcode"}, 32'(alu_opcode), 32'h0);
    chk({tagname, "_op_a"}, 32'(alu_op_a), 32'h0);
    chk({tagname, "_op_b"}, 32'(alu_op_b), 32'h0);
    chk({tagname, "_ex_valid"}, 32'(ex_valid), 32'h0);
    chk({tagname, "_illegal"}, 32'(illegal), 32'h0);
  endtask

  // Monitor: pops an expected event whenever the execute stage presents something
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        if (ex_valid || illegal) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 32'({ex_valid, illegal}), 32'h0);
          end else begin
            e = q.pop_front();
            chk("out_cycle", 32'(cyc), 32'(e.tag));
            chk("ex_valid", 32'(ex_valid), 32'(!e.ill));
            chk("illegal", 32'(illegal), 32'(e.ill));
            if (!e.ill) begin
              chk("alu_opcode", 32'(alu_opcode), 32'(e.op));
              chk("alu_op_a", 32'(alu_op_a), 32'(e.a));
              chk("alu_op_b", 32'(alu_op_b), 32'(e.b));
            end
          end
        end else if (q.size() > 0 && q[0].tag <= cyc) begin
          chk("missing_output", 32'(cyc), 32'(q[0].tag));
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    outputs_zero("rst_async");
    dbg_check();
    @(negedge clk);
    @(negedge clk);
    #3 reset = 1'b0;

    // MVI pair
    issue(1'b1, 1'b0, mk_i(4'hA, 3'd1, 8'h05));
    issue(1'b1, 1'b0, mk_i(4'hA, 3'd2, 8'h03));
    drain();
    dbg_check();

    // Bypass with wrap
    issue(1'b1, 1'b0, mk_i(4'hA, 3'd1, 8'hFF));
    issue(1'b1, 1'b0, mk_i(4'h4, 3'd1, 8'h02));
    drain();
    dbg_check();
    chk("r1_wrap", 32'(m[1]), 32'h01);

    // Bit set / clear then MOV
    issue(1'b1, 1'b0, mk_i(4'hA, 3'd3, 8'h0F));
    issue(1'b1, 1'b0, mk_i(4'h7, 3'd3, 8'hF0));
    issue(1'b1, 1'b0, mk_i(4'h6, 3'd3, 8'h01));
    issue(1'b1, 1'b0, mk_r(4'h8, 3'd4, 3'd3));
    drain();
    dbg_check();

    // Stall for 3 cycles with an ADD in execute, rd==rs dependency afterwards
    issue(1'b1, 1'b0, mk_i(4'hA, 3'd6, 8'h10));
    issue(1'b1, 1'b0, mk_i(4'hA, 3'd7, 8'h22));
    issue(1'b1, 1'b0, mk_r(4'h0, 3'd6, 3'd7));
    for (int i = 0; i < 3; i++) issue(1'b1, 1'b1, mk_r(4'h1, 3'd7, 3'd6));
    issue(1'b1, 1'b0, mk_r(4'h1, 3'd7, 3'd6));
    issue(1'b1, 1'b0, mk_r(4'h0, 3'd7, 3'd7));
    drain();
    dbg_check();

    // Undefined opcode between two valid instructions
    issue(1'b1, 1'b0, mk_i(4'hA, 3'd0, 8'h11));
    issue(1'b1, 1'b0, mk_i(4'hC, 3'd0, 8'h99));
    issue(1'b1, 1'b0, mk_i(4'hA, 3'd5, 8'h22));
    drain();
    dbg_check();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 16'($urandom));
    end
    drain();
    dbg_check();

    // Async reset mid-cycle with a writeback in flight
    issue(1'b1, 1'b0, mk_i(4'hA, 3'd5, 8'hAA));
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    q.delete();
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    instr_valid = 1'b0;
    outputs_zero("rst_mid");
    dbg_check();
    reset = 1'b0;
    issue(1'b1, 1'b0, mk_i(4'hA, 3'd2, 8'h7E));
    issue(1'b1, 1'b0, mk_r(4'h9, 3'd3, 3'd2));
    drain();
    dbg_check();

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_regfile.md
# decode_regfile

Operand-fetch and writeback stage wrapped around the combinational ALU in the 8-bit CPU datapath. It decodes a 16-bit instruction word and reads an 8-entry × 8-bit register file. It registers `opcode`/`op_a`/`op_b` into the execute pipeline register that drives the ALU, then writes the ALU `result` back into the register file one cycle later. A bypass path forwards the in-flight result to a dependent instruction, so back-to-back dependent instructions run without stalling.

## Interface
- `WIDTH`, 8, data/register width (fixed at 8 in this design; parameter for documentation only)
- `NREGS`, 8, register count (3-bit register addresses)
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `instr`  in  16  instruction word: [15:12] opcode, [11:9] rd, [8:6] rs, [7:0] imm8
- `instr_valid`  in  1  `instr` is valid this cycle
- `stall`  in  1  upstream/fetch hold; instruction not accepted while high
- `alu_result`  in  8  combinational result returned from the ALU
- `alu_opcode`  out  4  registered opcode to ALU
- `alu_op_a`  out  8  registered operand A to ALU
- `alu_op_b`  out  8  registered operand B to ALU
- `ex_valid`  out  1  execute register holds a real instruction
- `illegal`  out  1  one-cycle pulse: accepted instruction had an undefined opcode
- `dbg_addr`  in  3  debug read address
- `dbg_data`  out  8  combinational R[`dbg_addr`] (architectural value, no bypass)

## Operation
- Accept when `instr_valid && !stall`. Otherwise load a bubble into the execute register (`ex_valid`=0, `alu_opcode`/`alu_op_a`/`alu_op_b` hold previous values).
- Operand selection uses the shared opcode macros:
  - ADD, SUB, AND, OR: A=R[rd], B=R[rs]
  - ADDI, SUBI: A=R[rd], B=imm8
  - BC, BS: A=R[rd], B=imm8 (bit mask)
  - MOV, NOT: A=R[rs], B=0
  - MVI: A=imm8, B=0
- Undefined opcode: treat as a bubble (`ex_valid`=0) and pulse `illegal` the next cycle. No register write.
- The execute register also holds `ex_rd` (3 bits, internal).
- Writeback: on the edge ending an `ex_valid` cycle, R[`ex_rd`] <= `alu_result`. Every defined opcode writes rd.
- Bypass: when a source register read in decode equals `ex_rd` and `ex_valid`=1, use `alu_result` instead of the register file value. This applies to each operand independently, including rd==rs.
- Arithmetic is performed entirely by the ALU. This block does no arithmetic. Values are 8-bit and wrap modulo 256.
- `dbg_data` reflects committed state only.

## Timing
- Reset (async assert): R0–R7=0, `alu_opcode`=0, `alu_op_a`=0, `alu_op_b`=0, `ex_valid`=0, `illegal`=0, `ex_rd`=0. Release is synchronous to the next `clk` edge with no extra cycle.
- Latency: instruction accepted in cycle N → ALU inputs valid in cycle N+1 → register written at the edge ending N+1. The write is visible on `dbg_data` in cycle N+2.
- Throughput: one instruction per cycle. Dependent instructions need no stall.
- Stall with an instruction in execute: writeback of that instruction still completes, then a bubble follows.
- Simultaneous writeback and decode read of the same register: the bypass supplies the new value. A stale register-file read is a bug.
- Reset mid-operation: the in-flight writeback is dropped, and all registers read 0 after reset.
- `illegal` is high for exactly one cycle per illegal instruction, aligned with the cycle in which `ex_valid` would have been high.

## Test plan
- Reset, then read all `dbg_addr` 0–7 → all return 0x00. All outputs are 0 while `reset` is high, including when reset is asserted asynchronously mid-cycle.
- Send MVI r1,0x05 and then MVI r2,0x03, one per cycle. Two cycles after the last one is accepted, R1=0x05 and R2=0x03, and `alu_op_a` showed 0x05 then 0x03.
- Send MVI r1,0xFF immediately followed by ADDI r1,0x02, back-to-back. The second instruction's `alu_op_a`=0xFF through the bypass, and the final R1=0x01 (wrap).
- Set R3=0x0F, then send BS r3,0xF0 followed by BC r3,0x01. R3 becomes 0xFF, then 0xFE. On MOV r4,r3, `alu_op_a`=0xFE, B=0, and R4=0xFE.
- Present an instruction with `stall`=1 for 3 cycles while a prior ADD is in execute. The ADD still writes back, `ex_valid` is 0 for 3 cycles, and the held instruction executes once after `stall` drops.
- Send an undefined opcode between two valid instructions. `illegal` pulses for 1 cycle, `ex_valid`=0 in that slot, and no register changes.
